// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit RISC CPU control path: opcodes, instruction
// phases and the {PC_addr, PC_actve} address-mux select encodings.
package cpu_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  // Encoded as {PC_addr, PC_actve}
  localparam logic [1:0] SEL_INST = 2'b01;
  localparam logic [1:0] SEL_DATA = 2'b11;
  localparam logic [1:0] SEL_HOLD = 2'b00;

  function automatic logic is_aluop(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer and the CPU datapath: enable, opcode and
// zero flag in, mux selects, strobes, halt and phase out.
interface cpu_sequencer_if #(
  parameter int OPCODE_W = 3,
  parameter int PHASE_W  = 3
);
  logic                en;
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                PC_addr;
  logic                PC_actve;
  logic                rd;
  logic                wr;
  logic                ld_ir;
  logic                ld_ac;
  logic                ld_pc;
  logic                inc_pc;
  logic                data_e;
  logic                halt;
  logic [PHASE_W-1:0]  phase;

  modport master (
    input  en, opcode, zero,
    output PC_addr, PC_actve, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
  );

  modport slave (
    output en, opcode, zero,
    input  PC_addr, PC_actve, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase
  );
endinterface

// File: rtl/cpu_sequencer_phase_counter.sv
// Free-running instruction phase counter; advances on en unless held, and wraps
// naturally from the last phase back to 0.
module phase_counter #(
  parameter int PHASE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               hold,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_reg;
  logic [PHASE_W-1:0] phase_next;

  always_comb begin
    phase_next = phase_reg;
    if (en && !hold) begin
      phase_next = phase_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/cpu_sequencer.sv
// Central control FSM of the 8-bit RISC CPU: walks each instruction through
// eight phases and decodes the datapath strobes from phase, opcode and flags.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int PHASE_W  = 3
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);

  logic [PHASE_W-1:0]  phase_cnt;
  logic [OPCODE_W-1:0] op;
  phase_t              ph;
  logic                halted_reg;
  logic                halted_next;

  logic       aluop, sto, jmp, skz;
  logic [1:0] data_sel;
  logic [1:0] sel;
  logic       rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

  assign op = bus.opcode;
  assign ph = phase_t'(phase_cnt);

  // Once halted the counter is frozen, leaving phase parked at OP_FETCH.
  phase_counter #(.PHASE_W(PHASE_W)) u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.en),
    .hold  (halted_reg),
    .phase (phase_cnt)
  );

  always_comb begin
    halted_next = halted_reg;
    if (bus.en && (ph == PH_OP_ADDR) && (op == OP_HLT)) begin
      halted_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_reg <= 1'b0;
    end else begin
      halted_reg <= halted_next;
    end
  end

  assign aluop    = is_aluop(op);
  assign sto      = (op == OP_STO);
  assign jmp      = (op == OP_JMP);
  assign skz      = (op == OP_SKZ);
  assign data_sel = (aluop || sto) ? SEL_DATA : SEL_HOLD;

  always_comb begin
    sel    = SEL_HOLD;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = halted_reg;
    // Stalled or halted: everything quiet and the address mux holds.
    if (bus.en && !halted_reg) begin
      case (ph)
        PH_INST_ADDR: begin
          sel = SEL_INST;
        end
        PH_INST_FETCH: begin
          sel = SEL_INST;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = SEL_INST;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (op == OP_HLT);
        end
        PH_OP_FETCH: begin
          sel = data_sel;
          rd  = aluop;
        end
        PH_ALU_OP: begin
          sel    = data_sel;
          rd     = aluop;
          inc_pc = skz && bus.zero;
          ld_pc  = jmp;
          data_e = sto;
        end
        PH_STORE: begin
          sel    = data_sel;
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = jmp;
          wr     = sto;
          data_e = sto;
        end
        default: begin
          sel = SEL_HOLD;
        end
      endcase
    end
  end

  assign bus.PC_addr  = sel[1];
  assign bus.PC_actve = sel[0];
  assign bus.rd       = rd;
  assign bus.wr       = wr;
  assign bus.ld_ir    = ld_ir;
  assign bus.ld_ac    = ld_ac;
  assign bus.ld_pc    = ld_pc;
  assign bus.inc_pc   = inc_pc;
  assign bus.data_e   = data_e;
  assign bus.halt     = halt;
  assign bus.phase    = phase_cnt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed scenarios with literal expectations, then
// randomized stimulus, all cycles checked against a phase/halt reference model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction phase as an integer plus a halted flag.
  int m_ph    = 0;
  bit m_halt  = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph    <= 0;
      m_halt  <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_valid && bus.en && !m_halt) begin
      if (m_ph == 4 && bus.opcode == OP_HLT) m_halt <= 1'b1;
      m_ph <= (m_ph + 1) % 8;
    end
  end

  // Every-cycle comparison of all outputs against the rule set.
  always @(negedge clk) begin
    bit act, alu, sto, jmp, skz, dph;
    int op;
    if (m_valid) begin
      op  = int'(bus.opcode);
      act = bus.en && !m_halt;
      alu = (op == 2) || (op == 3) || (op == 4) || (op == 5);
      sto = (op == 6);
      jmp = (op == 7);
      skz = (op == 1);
      dph = (m_ph >= 5);
      cmp("phase",    int'(bus.phase),    m_ph);
      cmp("PC_addr",  int'(bus.PC_addr),  int'(act && dph && (alu || sto)));
      cmp("PC_actve", int'(bus.PC_actve), int'(act && (m_ph <= 3 || (dph && (alu || sto)))));
      cmp("rd",       int'(bus.rd),       int'(act && ((m_ph >= 1 && m_ph <= 3) || (dph && alu))));
      cmp("wr",       int'(bus.wr),       int'(act && m_ph == 7 && sto));
      cmp("ld_ir",    int'(bus.ld_ir),    int'(act && (m_ph == 2 || m_ph == 3)));
      cmp("ld_ac",    int'(bus.ld_ac),    int'(act && m_ph == 7 && alu));
      cmp("ld_pc",    int'(bus.ld_pc),    int'(act && m_ph >= 6 && jmp));
      cmp("inc_pc",   int'(bus.inc_pc),   int'(act && (m_ph == 4 || (m_ph == 6 && skz && bus.zero))));
      cmp("data_e",   int'(bus.data_e),   int'(act && m_ph >= 6 && sto));
      cmp("halt",     int'(bus.halt),     int'(m_halt || (act && m_ph == 4 && op == 0)));
      cmp("rd_wr_excl", int'(bus.rd && bus.wr), 0);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] rop;
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.opcode = OP_LDA;
    bus.zero   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);
    cmp("rst_phase",    int'(bus.phase), 0);
    cmp("rst_PC_actve", int'(bus.PC_actve), 1);
    cmp("rst_PC_addr",  int'(bus.PC_addr), 0);
    cmp("rst_halt",     int'(bus.halt), 0);

    // 1: LDA through all eight phases
    for (int p = 0; p < 8; p++) begin
      cmp("t1_phase", int'(bus.phase), p);
      cmp("t1_rd",    int'(bus.rd),    int'(p != 0 && p != 4));
      cmp("t1_ld_ir", int'(bus.ld_ir), int'(p == 2 || p == 3));
      cmp("t1_sel",   int'({bus.PC_addr, bus.PC_actve}), (p >= 5) ? 3 : (p == 4) ? 0 : 1);
      cmp("t1_ld_ac", int'(bus.ld_ac), int'(p == 7));
      adv();
      if (p == 7) bus.opcode = OP_STO;
      @(negedge clk);
    end
    $display("scenario 1 LDA instruction complete");

    // 2: STO
    for (int p = 0; p < 8; p++) begin
      cmp("t2_wr",     int'(bus.wr),     int'(p == 7));
      cmp("t2_data_e", int'(bus.data_e), int'(p >= 6));
      cmp("t2_rd",     int'(bus.rd),     int'(p >= 1 && p <= 3));
      adv();
      if (p == 7) begin
        bus.opcode = OP_SKZ;
        bus.zero   = 1'b1;
      end
      @(negedge clk);
    end
    $display("scenario 2 STO instruction complete");

    // 3: SKZ with zero=1, then zero=0
    for (int p = 0; p < 16; p++) begin
      cmp("t3_inc_pc", int'(bus.inc_pc), int'((p % 8) == 4 || (p == 6)));
      adv();
      if (p == 7) bus.zero = 1'b0;
      if (p == 15) bus.opcode = OP_HLT;
      @(negedge clk);
    end
    $display("scenario 3 SKZ instructions complete");

    // 4: HLT, held for 20 clocks, released only by rst
    for (int p = 0; p < 5; p++) begin
      if (p == 4) cmp("t4_halt_ph4", int'(bus.halt), 1);
      adv();
      @(negedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      cmp("t4_halt",  int'(bus.halt),  1);
      cmp("t4_phase", int'(bus.phase), 5);
      cmp("t4_strobes", int'({bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.ld_pc,
                              bus.inc_pc, bus.data_e, bus.PC_addr, bus.PC_actve}), 0);
      adv();
      bus.opcode = 3'($urandom_range(0, 7));
      if (k == 19) rst = 1'b1;
      @(negedge clk);
    end
    adv();
    rst        = 1'b0;
    bus.opcode = OP_LDA;
    @(negedge clk);
    cmp("t4_rst_phase", int'(bus.phase), 0);
    cmp("t4_rst_halt",  int'(bus.halt),  0);
    $display("scenario 4 HLT and reset release complete");

    // 5: stall for three clocks in phase 2
    adv();
    adv();
    bus.en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmp("t5_phase", int'(bus.phase), 2);
      cmp("t5_rd",    int'(bus.rd),    0);
      cmp("t5_ld_ir", int'(bus.ld_ir), 0);
      cmp("t5_sel",   int'({bus.PC_addr, bus.PC_actve}), 0);
      adv();
    end
    bus.en = 1'b1;
    @(negedge clk);
    cmp("t5_resume_phase", int'(bus.phase), 2);
    adv();
    @(negedge clk);
    cmp("t5_next_phase", int'(bus.phase), 3);
    $display("scenario 5 stall and resume complete");

    // 6: JMP interrupted by rst during phase 6
    bus.opcode = OP_JMP;
    adv();
    adv();
    adv();
    rst = 1'b1;
    @(negedge clk);
    cmp("t6_phase6", int'(bus.phase), 6);
    cmp("t6_ld_pc6", int'(bus.ld_pc), 1);
    adv();
    rst = 1'b0;
    @(negedge clk);
    cmp("t6_rst_phase", int'(bus.phase), 0);
    cmp("t6_ld_pc",     int'(bus.ld_pc), 0);
    $display("scenario 6 JMP reset drop complete");

    // Randomized traffic; opcode only changes while the IR is being loaded.
    for (int c = 0; c < 4000; c++) begin
      adv();
      rst    = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      bus.en = ($urandom_range(0, 9) != 0);
      bus.zero = 1'($urandom_range(0, 1));
      if (m_ph == 3) begin
        rop = 3'($urandom_range(0, 7));
        if (rop == OP_HLT && $urandom_range(0, 3) != 0) rop = OP_ADD;
        bus.opcode = rop;
      end
    end
    adv();
    $display("random phase: 4000 cycles applied");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
